// File: rtl/i2s_tx_serializer_pkg.sv
// Shared constants, types and helpers for the I2S transmit path and its
// frame-timing sub-block.
package i2s_pkg;

    localparam int SLOT_WIDTH_DEF = 16;
    localparam int PKT_WIDTH_DEF  = 16;
    localparam int FRAME_LEN      = 2 * SLOT_WIDTH_DEF;
    localparam int UNDERRUN_CNT_W = 8;

    typedef logic [$clog2(FRAME_LEN)-1:0] bit_cnt_t;

    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
        logic [UNDERRUN_CNT_W-1:0] r;
        if (v == {UNDERRUN_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(UNDERRUN_CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/i2s_tx_serializer_if.sv
// FIFO-side and codec-side signal bundle of the I2S transmit serializer.
// The serializer uses the slave view; the FIFO/codec environment uses master.
interface i2s_tx_serializer_if
    import i2s_pkg::*;
#(
    parameter int PKT_WIDTH = PKT_WIDTH_DEF
) ();

    logic [PKT_WIDTH-1:0]      pkt_i;
    logic                      pktChanged_i;
    logic                      enable_i;
    logic                      lrclk_o;
    logic                      sd_o;
    logic                      frameReq_o;
    logic                      underrun_o;
    logic [UNDERRUN_CNT_W-1:0] underrunCnt_o;

    modport master (
        output pkt_i, pktChanged_i, enable_i,
        input  lrclk_o, sd_o, frameReq_o, underrun_o, underrunCnt_o
    );

    modport slave (
        input  pkt_i, pktChanged_i, enable_i,
        output lrclk_o, sd_o, frameReq_o, underrun_o, underrunCnt_o
    );

endinterface

// File: rtl/i2s_tx_serializer_frame_counter.sv
// Free-running I2S frame timing: bit counter, word select, frame latch strobe
// and once-per-frame FIFO read request. Shared by the TX and RX paths.
module i2s_frame_counter
    import i2s_pkg::*;
#(
    parameter int SLOT_WIDTH = SLOT_WIDTH_DEF
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    output logic [$clog2(2*SLOT_WIDTH)-1:0]     next_bit_cnt_o,
    output logic                                lrclk_o,
    output logic                                latch_o,
    output logic                                frame_req_o
);

    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int CNT_W = $clog2(FRAME);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             lrclk_q;
    logic             frame_req_q;

    // Next bit position, wrapping at the end of the frame.
    always_comb begin
        if (cnt_q == CNT_W'(FRAME - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Registered counter; lrclk and frame request are decoded from the next
    // count so they line up with the counter value they describe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q       <= '0;
            lrclk_q     <= 1'b0;
            frame_req_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            lrclk_q     <= (cnt_d >= CNT_W'(SLOT_WIDTH));
            frame_req_q <= (cnt_d == CNT_W'(FRAME - 1));
        end
    end

    assign next_bit_cnt_o = cnt_d;
    assign lrclk_o        = lrclk_q;
    assign latch_o        = (cnt_q == '0);
    assign frame_req_o    = frame_req_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// I2S transmit serializer: holds the latest FIFO sample, latches it once per
// frame into both slots, shifts it out MSB first and flags underruns.
module i2s_tx_serializer
    import i2s_pkg::*;
#(
    parameter int PKT_WIDTH  = PKT_WIDTH_DEF,
    parameter int SLOT_WIDTH = SLOT_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    i2s_tx_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
    localparam int IDX_W = $clog2(SLOT_WIDTH);
    localparam int PAD_W = SLOT_WIDTH - PKT_WIDTH;

    function automatic logic [SLOT_WIDTH-1:0] pad(input logic [PKT_WIDTH-1:0] s);
        return SLOT_WIDTH'(s) << PAD_W;
    endfunction

    logic [CNT_W-1:0]          next_cnt_s;
    logic                      lrclk_s;
    logic                      latch_s;
    logic                      frame_req_s;
    logic [IDX_W-1:0]          idx_s;
    logic [PKT_WIDTH-1:0]      sample_s;

    logic [PKT_WIDTH-1:0]      hold_q,  hold_d;
    logic                      fresh_q, fresh_d;
    logic                      armed_q, armed_d;
    logic [SLOT_WIDTH-1:0]     tx_q,    tx_d;
    logic                      sd_q,    sd_d;
    logic                      ur_q,    ur_d;
    logic [UNDERRUN_CNT_W-1:0] ucnt_q,  ucnt_d;

    i2s_frame_counter #(
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_frame_counter (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .next_bit_cnt_o (next_cnt_s),
        .lrclk_o        (lrclk_s),
        .latch_o        (latch_s),
        .frame_req_o    (frame_req_s)
    );

    // Capture, frame latch and underrun decision; a strobe in the latch cycle
    // bypasses the hold register and counts as fresh.
    always_comb begin
        hold_d   = hold_q;
        fresh_d  = fresh_q;
        armed_d  = armed_q;
        tx_d     = tx_q;
        ur_d     = 1'b0;
        ucnt_d   = ucnt_q;
        sample_s = bus.pktChanged_i ? bus.pkt_i : hold_q;

        if (bus.pktChanged_i) begin
            hold_d  = bus.pkt_i;
            fresh_d = 1'b1;
            armed_d = 1'b1;
        end else begin
            hold_d  = hold_q;
        end

        if (latch_s) begin
            fresh_d = 1'b0;
            if (!bus.enable_i) begin
                tx_d = '0;
            end else if (bus.pktChanged_i || fresh_q) begin
                tx_d = pad(sample_s);
            end else if (armed_q) begin
                tx_d   = pad(hold_q);
                ur_d   = 1'b1;
                ucnt_d = sat_inc(ucnt_q);
            end else begin
                tx_d = pad(hold_q);
            end
        end else begin
            tx_d = tx_q;
        end
    end

    // Bit of txReg for the upcoming bit position: left slot at 1..S, right at
    // S+1..2S-1, right LSB trailing into position 0 of the next frame.
    always_comb begin
        if (next_cnt_s == '0) begin
            idx_s = '0;
        end else if (int'(next_cnt_s) <= SLOT_WIDTH) begin
            idx_s = IDX_W'(SLOT_WIDTH - int'(next_cnt_s));
        end else begin
            idx_s = IDX_W'(2 * SLOT_WIDTH - int'(next_cnt_s));
        end
        sd_d = tx_d[idx_s];
    end

    // Datapath and status registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            hold_q  <= '0;
            fresh_q <= 1'b0;
            armed_q <= 1'b0;
            tx_q    <= '0;
            sd_q    <= 1'b0;
            ur_q    <= 1'b0;
            ucnt_q  <= '0;
        end else begin
            hold_q  <= hold_d;
            fresh_q <= fresh_d;
            armed_q <= armed_d;
            tx_q    <= tx_d;
            sd_q    <= sd_d;
            ur_q    <= ur_d;
            ucnt_q  <= ucnt_d;
        end
    end

    assign bus.lrclk_o       = lrclk_s;
    assign bus.frameReq_o    = frame_req_s;
    assign bus.sd_o          = sd_q;
    assign bus.underrun_o    = ur_q;
    assign bus.underrunCnt_o = ucnt_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Randomized and directed bench for i2s_tx_serializer against a frame-level
// reference model (which sample each frame carries, underrun bookkeeping).
module tb_i2s_tx_serializer;
    import i2s_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2s_tx_serializer_if #(.PKT_WIDTH(16)) bus_a ();
    i2s_tx_serializer_if #(.PKT_WIDTH(12)) bus_b ();

    i2s_tx_serializer #(.PKT_WIDTH(16), .SLOT_WIDTH(16)) dut_a (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_a)
    );

    i2s_tx_serializer #(.PKT_WIDTH(12), .SLOT_WIDTH(16)) dut_b (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_b)
    );

    int checks = 0;
    int errors = 0;

    // frame-level model state
    int          bc;
    logic [15:0] hold;
    bit          fresh, armed, frame_active, ur_exp, en_r;
    int          ucnt;
    logic [15:0] cur_w;
    logic [31:0] sh_a, sh_b, last_a, last_b;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          lr_mis, fr_mis, ur_mis, cnt_mis, ur_seen;

    task automatic model_reset();
        bc = 0; hold = 16'h0; fresh = 1'b0; armed = 1'b0;
        frame_active = 1'b0; ur_exp = 1'b0; ucnt = 0;
        sh_a = 32'h0; sh_b = 32'h0; cur_w = 16'h0;
    endtask

    task automatic clear_stats();
        lr_mis = 0; fr_mis = 0; ur_mis = 0; cnt_mis = 0; ur_seen = 0;
        obs_q.delete(); exp_q.delete();
    endtask

    // One bit-clock cycle: observe outputs, drive inputs, advance the model.
    task automatic tick(input bit strobe, input logic [15:0] data, input bit en);
        if (bus_a.lrclk_o !== (bc >= 16)) lr_mis++;
        if (bus_a.frameReq_o !== (bc == 31)) fr_mis++;
        if (bus_a.underrun_o !== ur_exp) ur_mis++;
        if (bus_a.underrun_o === 1'b1) ur_seen++;
        if (bus_a.underrunCnt_o !== 8'(ucnt)) cnt_mis++;
        if (frame_active) begin
            sh_a = {sh_a[30:0], bus_a.sd_o};
            sh_b = {sh_b[30:0], bus_b.sd_o};
            if (bc == 0) begin
                obs_q.push_back(sh_a);
                exp_q.push_back({cur_w, cur_w});
                last_a = sh_a;
                last_b = sh_b;
            end
        end
        bus_a.pkt_i = data;  bus_a.pktChanged_i = strobe; bus_a.enable_i = en;
        bus_b.pkt_i = 12'hFFF; bus_b.pktChanged_i = strobe; bus_b.enable_i = en;
        ur_exp = 1'b0;
        if (strobe) begin
            hold = data; fresh = 1'b1; armed = 1'b1;
        end
        if (bc == 0) begin
            cur_w  = en ? hold : 16'h0;
            ur_exp = en && !fresh && armed;
            if (ur_exp && ucnt < 255) ucnt++;
            fresh = 1'b0;
            frame_active = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        bc = (bc + 1) % 32;
    endtask

    task automatic run_to(input int target);
        while (bc != target) tick(1'b0, 16'h0, en_r);
    endtask

    // Latch at bc 0 already done by caller; finish the frame and sample its last bit.
    task automatic finish_frame();
        repeat (31) tick(1'b0, 16'h0, en_r);
        tick(1'b0, 16'h0, en_r);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus_a.pktChanged_i = 1'b0; bus_b.pktChanged_i = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_stats();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (bus_a.lrclk_o !== 1'b0) begin errors++; $display("FAIL reset_lrclk: got %b expected 0", bus_a.lrclk_o); end
        checks++; if (bus_a.sd_o !== 1'b0) begin errors++; $display("FAIL reset_sd: got %b expected 0", bus_a.sd_o); end
        checks++; if (bus_a.frameReq_o !== 1'b0) begin errors++; $display("FAIL reset_framereq: got %b expected 0", bus_a.frameReq_o); end
        checks++; if (bus_a.underrun_o !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b expected 0", bus_a.underrun_o); end
        checks++; if (bus_a.underrunCnt_o !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus_a.underrunCnt_o); end
        rst_n = 1'b1;
        model_reset();
        clear_stats();
        repeat (96) tick(1'b0, 16'h0, 1'b1);
        checks++; if (lr_mis !== 0) begin errors++; $display("FAIL idle_lrclk: %0d bad cycles expected 0", lr_mis); end
        checks++; if (fr_mis !== 0) begin errors++; $display("FAIL idle_framereq: %0d bad cycles expected 0", fr_mis); end
        checks++; if (ur_seen !== 0) begin errors++; $display("FAIL idle_no_underrun: %0d pulses expected 0", ur_seen); end
        checks++; if (last_a !== 32'h0) begin errors++; $display("FAIL idle_frame: got %h expected 00000000", last_a); end
    endtask

    task automatic test_basic();
        int ur0;
        ur0 = ur_seen;
        run_to(5);
        tick(1'b1, 16'hA5C3, 1'b1);
        run_to(0);
        tick(1'b0, 16'h0, 1'b1);
        finish_frame();
        checks++; if (last_a !== 32'hA5C3A5C3) begin errors++; $display("FAIL basic_frame: got %h expected a5c3a5c3", last_a); end
        checks++; if (ur_seen !== ur0) begin errors++; $display("FAIL basic_no_underrun: got %0d pulses expected %0d", ur_seen, ur0); end
    endtask

    task automatic test_underrun();
        apply_reset();
        run_to(7);
        tick(1'b1, 16'h1234, 1'b1);
        run_to(0);
        tick(1'b0, 16'h0, 1'b1);
        run_to(0);
        tick(1'b0, 16'h0, 1'b1);
        checks++; if (bus_a.underrun_o !== 1'b1) begin errors++; $display("FAIL underrun_pulse: got %b expected 1", bus_a.underrun_o); end
        checks++; if (bus_a.underrunCnt_o !== 8'd1) begin errors++; $display("FAIL underrun_cnt1: got %0d expected 1", bus_a.underrunCnt_o); end
        repeat (300 * 32) tick(1'b0, 16'h0, 1'b1);
        checks++; if (bus_a.underrunCnt_o !== 8'd255) begin errors++; $display("FAIL underrun_sat: got %0d expected 255", bus_a.underrunCnt_o); end
        checks++; if (last_a !== 32'h12341234) begin errors++; $display("FAIL underrun_repeat: got %h expected 12341234", last_a); end
        checks++; if (ur_mis !== 0) begin errors++; $display("FAIL underrun_pulses: %0d bad cycles expected 0", ur_mis); end
        checks++; if (cnt_mis !== 0) begin errors++; $display("FAIL underrun_count_track: %0d bad cycles expected 0", cnt_mis); end
    endtask

    task automatic test_bypass();
        run_to(0);
        tick(1'b1, 16'h8001, 1'b1);
        checks++; if (bus_a.sd_o !== 1'b1) begin errors++; $display("FAIL bypass_msb: got %b expected 1", bus_a.sd_o); end
        checks++; if (bus_a.underrun_o !== 1'b0) begin errors++; $display("FAIL bypass_no_underrun: got %b expected 0", bus_a.underrun_o); end
        finish_frame();
        checks++; if (last_a !== 32'h80018001) begin errors++; $display("FAIL bypass_frame: got %h expected 80018001", last_a); end
        run_to(3);
        tick(1'b1, 16'h0F0F, 1'b1);
        run_to(9);
        tick(1'b1, 16'h7777, 1'b1);
        run_to(0);
        tick(1'b0, 16'h0, 1'b1);
        finish_frame();
        checks++; if (last_a !== 32'h77777777) begin errors++; $display("FAIL last_strobe_wins: got %h expected 77777777", last_a); end
    endtask

    task automatic test_width_mute();
        logic [15:0] d;
        apply_reset();
        d = 16'($urandom);
        run_to(4);
        tick(1'b1, d, 1'b1);
        run_to(0);
        tick(1'b0, 16'h0, 1'b1);
        repeat (31) tick(1'b0, 16'h0, 1'b1);
        en_r = 1'b0;
        tick(1'b0, 16'h0, 1'b0);
        checks++; if (last_b !== 32'hFFF0FFF0) begin errors++; $display("FAIL width_pad: got %h expected fff0fff0", last_b); end
        checks++; if (last_a !== {d, d}) begin errors++; $display("FAIL width_ref_frame: got %h expected %h", last_a, {d, d}); end
        finish_frame();
        checks++; if (last_a !== 32'h0) begin errors++; $display("FAIL mute_frame: got %h expected 00000000", last_a); end
        checks++; if (last_b !== 32'h0) begin errors++; $display("FAIL mute_frame_w12: got %h expected 00000000", last_b); end
        checks++; if (bus_a.underrunCnt_o !== 8'd0) begin errors++; $display("FAIL mute_cnt: got %0d expected 0", bus_a.underrunCnt_o); end
        en_r = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic [15:0] d;
        repeat (64) tick(1'b0, 16'h0, 1'b1);
        run_to(20);
        checks++; if (bus_a.underrunCnt_o !== 8'(ucnt)) begin errors++; $display("FAIL prereset_cnt: got %0d expected %0d", bus_a.underrunCnt_o, ucnt); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus_a.lrclk_o !== 1'b0) begin errors++; $display("FAIL async_lrclk: got %b expected 0", bus_a.lrclk_o); end
        checks++; if (bus_a.sd_o !== 1'b0) begin errors++; $display("FAIL async_sd: got %b expected 0", bus_a.sd_o); end
        checks++; if (bus_a.underrunCnt_o !== 8'd0) begin errors++; $display("FAIL async_cnt: got %0d expected 0", bus_a.underrunCnt_o); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        clear_stats();
        d = 16'($urandom) | 16'h8000;
        tick(1'b1, d, 1'b1);
        checks++; if (bus_a.sd_o !== 1'b1) begin errors++; $display("FAIL restart_latch: got %b expected 1", bus_a.sd_o); end
        finish_frame();
        checks++; if (last_a !== {d, d}) begin errors++; $display("FAIL restart_frame: got %h expected %h", last_a, {d, d}); end
    endtask

    task automatic test_random();
        logic [31:0] o, e;
        int nf;
        clear_stats();
        for (int i = 0; i < 48 * 32; i++) begin
            tick(($urandom_range(0, 39) == 0), 16'($urandom), ($urandom_range(0, 7) != 0));
        end
        nf = obs_q.size();
        checks++; if (nf < 40) begin errors++; $display("FAIL random_frame_count: got %0d expected at least 40", nf); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL random_frame: got %h expected %h", o, e); end
        end
        checks++; if (lr_mis !== 0) begin errors++; $display("FAIL random_lrclk: %0d bad cycles expected 0", lr_mis); end
        checks++; if (fr_mis !== 0) begin errors++; $display("FAIL random_framereq: %0d bad cycles expected 0", fr_mis); end
        checks++; if (ur_mis !== 0) begin errors++; $display("FAIL random_underrun: %0d bad cycles expected 0", ur_mis); end
        checks++; if (cnt_mis !== 0) begin errors++; $display("FAIL random_count: %0d bad cycles expected 0", cnt_mis); end
    endtask

    initial begin
        bus_a.pkt_i = 16'h0; bus_a.pktChanged_i = 1'b0; bus_a.enable_i = 1'b1;
        bus_b.pkt_i = 12'h0; bus_b.pktChanged_i = 1'b0; bus_b.enable_i = 1'b1;
        en_r   = 1'b1;
        last_a = 32'h0;
        last_b = 32'h0;
        model_reset();
        clear_stats();
        test_reset();
        test_basic();
        test_underrun();
        test_bypass();
        test_width_mute();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
